counter_16: RTL and testbench

COUNTER_16 -- requirements
Module: counter_16

---
 rtl/tff_en.sv | 29 ++
 rtl/counter_16.sv | 31 +++
 tb/tb_counter_16.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tff_en.sv
// T flip-flop with toggle enable and asynchronous active-high clear.
// Internally a D flip-flop whose next state is q XOR t.
module tff_en (
    input  logic clk,
    input  logic clr,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; the clear is in the sensitivity list so it acts without a clock.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/counter_16.sv
// Fully synchronous modulo-2^WIDTH up counter built from tff_en bits
// with an AND carry chain; tc flags the enabled all-ones state.
module counter_16 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ena,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    // carry[i] is the toggle for bit i: ena AND all lower bits set.
    logic [WIDTH:0] carry;

    assign carry[0] = ena;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign carry[i+1] = carry[i] & out[i];

        tff_en u_tff (
            .clk (clk),
            .clr (clrn),
            .t   (carry[i]),
            .q   (out[i])
        );
    end

    assign tc = carry[WIDTH] & ~clrn;

endmodule

// File: tb/tb_counter_16.sv
// Randomized self-checking bench for counter_16 at WIDTH=4 and WIDTH=3,
// compared every cycle against an arithmetic modulo-count model.
module tb_counter_16;

    logic       clk  = 1'b0;
    logic       clrn = 1'b1;
    logic       ena  = 1'b0;
    logic [3:0] out4;
    logic       tc4;
    logic [2:0] out3;
    logic       tc3;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference counts: plain integers advanced modulo 16 and 8.
    int m4 = 0;
    int m3 = 0;

    always #5 clk = ~clk;

    counter_16 #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .clrn (clrn),
        .ena  (ena),
        .out  (out4),
        .tc   (tc4)
    );

    counter_16 #(.WIDTH(3)) u_dut3 (
        .clk  (clk),
        .clrn (clrn),
        .ena  (ena),
        .out  (out3),
        .tc   (tc3)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge clrn) begin
        if (clrn) begin
            m4 = 0;
            m3 = 0;
        end else if (ena) begin
            m4 = (m4 + 1) % 16;
            m3 = (m3 + 1) % 8;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out4", int'(out4), clrn ? 0 : m4);
            check("tc4",  int'(tc4),  (ena && !clrn && m4 == 15) ? 1 : 0);
            check("out3", int'(out3), clrn ? 0 : m3);
            check("tc3",  int'(tc3),  (ena && !clrn && m3 == 7) ? 1 : 0);
        end
    end

    initial begin
        // Reset held with ena low for ten cycles.
        repeat (10) begin
            @(negedge clk);
            chk_en = 1'b1;
            check("rst_out4", int'(out4), 0);
            check("rst_tc4",  int'(tc4),  0);
        end

        // Release and count 16 edges: 1..15,0 with tc only at 15.
        @(posedge clk);
        #2;
        clrn = 1'b0;
        ena  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("seq_out4", int'(out4), i % 16);
            check("seq_tc4",  int'(tc4),  (i == 15) ? 1 : 0);
            check("seq_out3", int'(out3), i % 8);
            check("seq_tc3",  int'(tc3),  (i % 8 == 7) ? 1 : 0);
        end

        // Count to 5, then hold for two edges and resume.
        repeat (5) @(posedge clk);
        #2;
        ena = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("hold_out4", int'(out4), 5);
        check("hold_out3", int'(out3), 5);
        @(posedge clk);
        #2;
        ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("resume_out4", int'(out4), 6);

        // Clear mid-cycle at count 9: out drops before any edge.
        repeat (3) @(posedge clk);
        #2;
        check("pre_clr_out4", int'(out4), 9);
        clrn = 1'b1;
        #1;
        check("async_clr_out4", int'(out4), 0);
        check("async_clr_out3", int'(out3), 0);
        #1;
        clrn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_clr1_out4", int'(out4), 1);
        @(posedge clk);
        @(negedge clk);
        check("post_clr2_out4", int'(out4), 2);

        // Clear and enable together: clear wins on every edge.
        @(posedge clk);
        #2;
        clrn = 1'b1;
        ena  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("clr_ena_out4", int'(out4), 0);
        check("clr_ena_tc4",  int'(tc4),  0);
        @(posedge clk);
        #2;
        clrn = 1'b0;

        // Random enable/clear traffic, with occasional between-edge clear pulses.
        repeat (400) begin
            @(posedge clk);
            #2;
            ena  = ($urandom_range(0, 3) != 0);
            clrn = ($urandom_range(0, 15) == 0);
            if (!clrn && $urandom_range(0, 15) == 0) begin
                clrn = 1'b1;
                #1;
                check("rnd_async_out4", int'(out4), 0);
                #1;
                clrn = 1'b0;
            end
        end

        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
